l2_cache_controller: RTL and testbench
======================================

# l2_cache_controller

Sequencing controller for the L2 cache datapath: arbitrates between L1 requests (data read, data write, instruction read) and shared-bus snoops (R/W/M/I), drives the tag-lookup and LRU-update strobes of the L2 storage, and issues shared-bus transactions on misses and shared-line writes. It also maintains the hit/miss/read/write statistics counters. It sits between the L1 interface, the shared-bus interface and the L2 tag/data/LRU arrays.

## Interface
Parameters:
- addrBits, 32, physical address width
- ways, 8, associativity; way index width is $clog2(ways)
- counterBits, 32, width of each statistics counter

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- l1Valid  input  1  L1 request present
- l1Op  input  2  0=DR, 1=DW, 2=IR; 3 is reserved and treated as DR
- l1Addr  input  addrBits  L1 request address
- l1Ready  output  1  L1 request accepted this cycle
- snoopValid  input  1  snoop present
- snoopOp  input  2  0=R, 1=W, 2=M, 3=I
- snoopAddr  input  addrBits  snoop address
- snoopReady  output  1  snoop accepted this cycle
- lookupStart  output  1  one-cycle tag-lookup strobe
- lookupAddr  output  addrBits  captured request address, stable from accept until return to IDLE
- lookupHit  input  1  lookup result, valid the cycle after lookupStart
- lookupWay  input  $clog2(ways)  hitting way (or LRU victim on miss), valid with lookupHit
- lookupMesi  input  4  MESI state of the hitting line, one-hot
- lruUpdate  output  1  one-cycle strobe: make lruWay MRU
- lruWay  output  $clog2(ways)  way to update
- busReqValid  output  1  shared-bus transaction request
- busReqOp  output  2  R/W/M/I encoding as snoopOp
- busGrant  input  1  shared bus granted
- busDone  input  1  shared-bus transaction complete
- snoopRespValid  output  1  one-cycle snoop response strobe
- snoopHit  output  1  snooped line present
- snoopHitM  output  1  snooped line present in Modified
- done  output  1  one-cycle pulse: L1 request complete
- hitCount, missCount, readCount, writeCount  output  counterBits  saturating statistics

## Operation
- States: IDLE, LOOKUP, COMPARE, BUS_REQ, BUS_WAIT, UPDATE, RESPOND.
- IDLE arbitration: snoop has priority; 2-bit snoopStreak counts consecutive snoop grants while l1Valid is high. When streak==3 and l1Valid is high, L1 wins and the streak clears. The streak also clears on any L1 grant.
- Exactly one of l1Ready/snoopReady is high, only in IDLE, combinationally for the winner. Address, op and source are captured on valid&ready.
- LOOKUP: lookupStart=1 → COMPARE.
- COMPARE (samples lookup inputs, latches lookupWay):
  - snoop → RESPOND
  - L1 hit, DR/IR → UPDATE
  - L1 hit, DW with MESI S → BUS_REQ, op I
  - L1 hit, DW otherwise → UPDATE
  - L1 miss, DR/IR → BUS_REQ, op R
  - L1 miss, DW → BUS_REQ, op M (read-for-ownership)
- BUS_REQ: busReqValid held high with busReqOp and lookupAddr stable until busGrant → BUS_WAIT.
- BUS_WAIT: wait for busDone → UPDATE. busDone is ignored outside BUS_WAIT.
- UPDATE: lruUpdate=1, lruWay=latched way, done=1 → IDLE.
- RESPOND: snoopRespValid=1, snoopHit=latched hit, snoopHitM=hit&&MESI==M → IDLE. No LRU update for snoops.
- Counters update in COMPARE for L1 requests only:
  - hitCount or missCount +1
  - readCount +1 for DR/IR, writeCount +1 for DW
  - all saturate at all-ones; snoops never count.

## Timing
- Reset (async, any state): state=IDLE, streak=0, every output 0 including counters, lookupAddr=0, lruWay=0. l1Ready/snoopReady may rise in the first cycle after deassertion if a request is present.
- Accept at cycle 0 → lookupStart cycle 1 → COMPARE cycle 2.
- L1 hit: done/lruUpdate at cycle 3; next accept possible at cycle 4.
- Snoop: snoopRespValid at cycle 3.
- Miss: busReqValid from cycle 3. With grant at cycle g and busDone at cycle d>g, done is asserted at cycle d+1.
- busGrant in the same cycle busReqValid first rises is legal; the controller enters BUS_WAIT next cycle.
- Simultaneous l1Valid and snoopValid with streak<3: snoop wins; L1 waits with l1Ready=0.

## Structure
- Package l2_pkg holds:
  - L1 op constants DR/DW/IR
  - bus op constants R/W/M/I
  - MESI one-hot constants: I=4'b0001, S=4'b0010, E=4'b0100, M=4'b1000
  - state enum
- Sub-module l2_event_counters: four saturating counters with increment enables. The FSM stays in l2_cache_controller.

## Test plan
- Reset, then L1 DR at 0x00001040 with lookupHit=1, way=5, MESI E → lookupStart cycle 1, done+lruUpdate(way 5) cycle 3, hitCount=1, readCount=1.
- L1 DW miss, way=2, grant 2 cycles later, busDone 4 cycles after grant → busReqOp=M held until grant, done 1 cycle after busDone, missCount=1, writeCount=1.
- L1 DW hit, MESI S → busReqOp=I, then lruUpdate; snoop R hit in M → snoopHit=1, snoopHitM=1, no lruUpdate.
- snoopValid and l1Valid held high continuously → three snoop grants, then one L1 grant, pattern repeats.
- Preload counters to all-ones−1, issue two hits → hitCount sticks at all-ones; assert rst_n=0 during BUS_WAIT → all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared constants and state encoding for the L2 cache sequencing controller.
package l2_pkg;

    localparam logic [1:0] L1_DR = 2'd0;
    localparam logic [1:0] L1_DW = 2'd1;
    localparam logic [1:0] L1_IR = 2'd2;

    localparam logic [1:0] BUS_R = 2'd0;
    localparam logic [1:0] BUS_W = 2'd1;
    localparam logic [1:0] BUS_M = 2'd2;
    localparam logic [1:0] BUS_I = 2'd3;

    localparam logic [3:0] MESI_I = 4'b0001;
    localparam logic [3:0] MESI_S = 4'b0010;
    localparam logic [3:0] MESI_E = 4'b0100;
    localparam logic [3:0] MESI_M = 4'b1000;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StCompare,
        StBusReq,
        StBusWait,
        StUpdate,
        StRespond
    } state_e;

endpackage

// File: rtl/l2_event_counters.sv
// Four saturating statistics counters (hit, miss, read, write) with increment enables.
module l2_event_counters #(
    parameter int unsigned counterBits = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   hit_inc_i,
    input  logic                   miss_inc_i,
    input  logic                   read_inc_i,
    input  logic                   write_inc_i,
    output logic [counterBits-1:0] hit_cnt_o,
    output logic [counterBits-1:0] miss_cnt_o,
    output logic [counterBits-1:0] read_cnt_o,
    output logic [counterBits-1:0] write_cnt_o
);

    localparam logic [counterBits-1:0] One = counterBits'(1);

    logic [3:0]                  inc;
    logic [3:0][counterBits-1:0] cnt_q;
    logic [3:0][counterBits-1:0] cnt_d;

    assign inc = {write_inc_i, read_inc_i, miss_inc_i, hit_inc_i};

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            // Stick at all-ones rather than wrapping.
            if (inc[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + One;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt_o   = cnt_q[0];
    assign miss_cnt_o  = cnt_q[1];
    assign read_cnt_o  = cnt_q[2];
    assign write_cnt_o = cnt_q[3];

endmodule

// File: rtl/l2_cache_controller.sv
// L2 sequencing FSM: arbitrates L1 requests against snoops, strobes tag lookup and LRU update,
// and issues shared-bus transactions on misses and writes to shared lines.
module l2_cache_controller
    import l2_pkg::*;
#(
    parameter int unsigned addrBits    = 32,
    parameter int unsigned ways        = 8,
    parameter int unsigned counterBits = 32,
    localparam int unsigned WayBits    = (ways > 1) ? $clog2(ways) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   l1Valid,
    input  logic [1:0]             l1Op,
    input  logic [addrBits-1:0]    l1Addr,
    output logic                   l1Ready,
    input  logic                   snoopValid,
    input  logic [1:0]             snoopOp,
    input  logic [addrBits-1:0]    snoopAddr,
    output logic                   snoopReady,
    output logic                   lookupStart,
    output logic [addrBits-1:0]    lookupAddr,
    input  logic                   lookupHit,
    input  logic [WayBits-1:0]     lookupWay,
    input  logic [3:0]             lookupMesi,
    output logic                   lruUpdate,
    output logic [WayBits-1:0]     lruWay,
    output logic                   busReqValid,
    output logic [1:0]             busReqOp,
    input  logic                   busGrant,
    input  logic                   busDone,
    output logic                   snoopRespValid,
    output logic                   snoopHit,
    output logic                   snoopHitM,
    output logic                   done,
    output logic [counterBits-1:0] hitCount,
    output logic [counterBits-1:0] missCount,
    output logic [counterBits-1:0] readCount,
    output logic [counterBits-1:0] writeCount
);

    state_e                state_q, state_d;
    logic [1:0]            streak_q, streak_d;
    logic [addrBits-1:0]   addr_q, addr_d;
    logic [1:0]            op_q, op_d;
    logic                  src_snoop_q, src_snoop_d;
    logic [WayBits-1:0]    way_q, way_d;
    logic                  hit_q, hit_d;
    logic                  hit_m_q, hit_m_d;
    logic [1:0]            bus_op_q, bus_op_d;

    logic l1_win;
    logic idle;
    logic cmp_l1;

    assign idle   = (state_q == StIdle);
    // L1 wins when no snoop competes, or after three back-to-back snoop grants starved it.
    assign l1_win = l1Valid && (!snoopValid || (streak_q == 2'd3));

    assign l1Ready    = idle && l1_win;
    assign snoopReady = idle && snoopValid && !l1_win;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        addr_d      = addr_q;
        op_d        = op_q;
        src_snoop_d = src_snoop_q;
        way_d       = way_q;
        hit_d       = hit_q;
        hit_m_d     = hit_m_q;
        bus_op_d    = bus_op_q;

        unique case (state_q)
            StIdle: begin
                if (l1Ready) begin
                    state_d     = StLookup;
                    streak_d    = 2'd0;
                    addr_d      = l1Addr;
                    src_snoop_d = 1'b0;
                    op_d        = (l1Op == L1_DW) ? L1_DW : ((l1Op == L1_IR) ? L1_IR : L1_DR);
                end else if (snoopReady) begin
                    state_d     = StLookup;
                    streak_d    = l1Valid ? streak_q + 2'd1 : 2'd0;
                    addr_d      = snoopAddr;
                    src_snoop_d = 1'b1;
                    op_d        = snoopOp;
                end
            end
            StLookup: begin
                state_d = StCompare;
            end
            StCompare: begin
                way_d   = lookupWay;
                hit_d   = lookupHit;
                hit_m_d = lookupHit && (lookupMesi == MESI_M);
                if (src_snoop_q) begin
                    state_d = StRespond;
                end else if (lookupHit) begin
                    if ((op_q == L1_DW) && (lookupMesi == MESI_S)) begin
                        state_d  = StBusReq;
                        bus_op_d = BUS_I;
                    end else begin
                        state_d = StUpdate;
                    end
                end else begin
                    state_d  = StBusReq;
                    bus_op_d = (op_q == L1_DW) ? BUS_M : BUS_R;
                end
            end
            StBusReq: begin
                if (busGrant) begin
                    state_d = StBusWait;
                end
            end
            StBusWait: begin
                if (busDone) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                state_d = StIdle;
            end
            StRespond: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            streak_q    <= 2'd0;
            addr_q      <= '0;
            op_q        <= L1_DR;
            src_snoop_q <= 1'b0;
            way_q       <= '0;
            hit_q       <= 1'b0;
            hit_m_q     <= 1'b0;
            bus_op_q    <= BUS_R;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            src_snoop_q <= src_snoop_d;
            way_q       <= way_d;
            hit_q       <= hit_d;
            hit_m_q     <= hit_m_d;
            bus_op_q    <= bus_op_d;
        end
    end

    assign lookupStart    = (state_q == StLookup);
    assign lookupAddr     = addr_q;
    assign busReqValid    = (state_q == StBusReq);
    assign busReqOp       = bus_op_q;
    assign lruUpdate      = (state_q == StUpdate);
    assign lruWay         = way_q;
    assign done           = (state_q == StUpdate);
    assign snoopRespValid = (state_q == StRespond);
    assign snoopHit       = snoopRespValid && hit_q;
    assign snoopHitM      = snoopRespValid && hit_m_q;

    assign cmp_l1 = (state_q == StCompare) && !src_snoop_q;

    l2_event_counters #(
        .counterBits(counterBits)
    ) u_counters (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .hit_inc_i   (cmp_l1 && lookupHit),
        .miss_inc_i  (cmp_l1 && !lookupHit),
        .read_inc_i  (cmp_l1 && (op_q != L1_DW)),
        .write_inc_i (cmp_l1 && (op_q == L1_DW)),
        .hit_cnt_o   (hitCount),
        .miss_cnt_o  (missCount),
        .read_cnt_o  (readCount),
        .write_cnt_o (writeCount)
    );

endmodule

// File: tb/tb_l2_cache_controller.sv
// Directed bench for l2_cache_controller; narrow counters make saturation reachable.
module tb_l2_cache_controller;
    import l2_pkg::*;

    localparam int unsigned CB = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        l1Valid, snoopValid, lookupHit, busGrant, busDone;
    logic [1:0]  l1Op, snoopOp, busReqOp;
    logic [31:0] l1Addr, snoopAddr, lookupAddr;
    logic [2:0]  lookupWay, lruWay;
    logic [3:0]  lookupMesi;
    logic        l1Ready, snoopReady, lookupStart, lruUpdate, busReqValid;
    logic        snoopRespValid, snoopHit, snoopHitM, done;
    logic [CB-1:0] hitCount, missCount, readCount, writeCount;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    l2_cache_controller #(
        .addrBits(32),
        .ways(8),
        .counterBits(CB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .l1Valid(l1Valid), .l1Op(l1Op), .l1Addr(l1Addr), .l1Ready(l1Ready),
        .snoopValid(snoopValid), .snoopOp(snoopOp), .snoopAddr(snoopAddr),
        .snoopReady(snoopReady),
        .lookupStart(lookupStart), .lookupAddr(lookupAddr), .lookupHit(lookupHit),
        .lookupWay(lookupWay), .lookupMesi(lookupMesi),
        .lruUpdate(lruUpdate), .lruWay(lruWay),
        .busReqValid(busReqValid), .busReqOp(busReqOp), .busGrant(busGrant),
        .busDone(busDone),
        .snoopRespValid(snoopRespValid), .snoopHit(snoopHit), .snoopHitM(snoopHitM),
        .done(done),
        .hitCount(hitCount), .missCount(missCount), .readCount(readCount),
        .writeCount(writeCount)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full L1 hit transaction starting in an idle cycle; returns in the next idle cycle.
    task automatic l1_hit(input logic [1:0] op, input logic [31:0] addr, input logic [2:0] way);
        l1Valid = 1'b1; l1Op = op; l1Addr = addr;
        lookupHit = 1'b1; lookupWay = way; lookupMesi = MESI_E;
        #1 chk("hit_ready", l1Ready, 1);
        tick();
        l1Valid = 1'b0;
        #1;
        chk("hit_lookup", lookupStart, 1);
        chk("hit_addr", lookupAddr, addr);
        tick();
        chk("hit_cmp_nodone", done, 0);
        tick();
        chk("hit_done", done, 1);
        chk("hit_lru", lruUpdate, 1);
        chk("hit_way", lruWay, way);
        tick();
    endtask

    task automatic snoop(input logic [1:0] op, input logic [3:0] mesi, input logic exp_m);
        snoopValid = 1'b1; snoopOp = op; snoopAddr = 32'h0000_4000;
        lookupHit = 1'b1; lookupWay = 3'd6; lookupMesi = mesi;
        #1;
        chk("snp_ready", snoopReady, 1);
        chk("snp_l1_notready", l1Ready, 0);
        tick();
        snoopValid = 1'b0;
        tick();
        tick();
        chk("snp_resp", snoopRespValid, 1);
        chk("snp_hit", snoopHit, 1);
        chk("snp_hitm", snoopHitM, exp_m);
        chk("snp_no_lru", lruUpdate, 0);
        chk("snp_no_done", done, 0);
        tick();
        chk("snp_resp_clear", snoopRespValid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        l1Valid = 1'b0; l1Op = L1_DR; l1Addr = '0;
        snoopValid = 1'b0; snoopOp = BUS_R; snoopAddr = '0;
        lookupHit = 1'b0; lookupWay = '0; lookupMesi = MESI_I;
        busGrant = 1'b0; busDone = 1'b0;
        tick();
        tick();
        chk("rst_done", done, 0);
        chk("rst_busreq", busReqValid, 0);
        chk("rst_hitcnt", hitCount, 0);
        chk("rst_addr", lookupAddr, 0);
        rst_n = 1'b1;
        tick();

        // L1 DR hit, way 5, MESI E
        l1_hit(L1_DR, 32'h0000_1040, 3'd5);
        chk("t1_hitcnt", hitCount, 1);
        chk("t1_readcnt", readCount, 1);
        chk("t1_misscnt", missCount, 0);

        // L1 DW miss, way 2: grant at c5, busDone at c9, done at c10
        l1Valid = 1'b1; l1Op = L1_DW; l1Addr = 32'h0000_2000;
        lookupHit = 1'b0; lookupWay = 3'd2; lookupMesi = MESI_I;
        #1 chk("t2_ready", l1Ready, 1);
        tick(); l1Valid = 1'b0;
        tick();
        tick();
        chk("t2_busreq_c3", busReqValid, 1);
        chk("t2_busop_c3", busReqOp, BUS_M);
        chk("t2_busaddr", lookupAddr, 32'h0000_2000);
        tick();
        chk("t2_busreq_c4", busReqValid, 1);
        chk("t2_busop_c4", busReqOp, BUS_M);
        tick(); busGrant = 1'b1;
        #1 chk("t2_busreq_c5", busReqValid, 1);
        tick(); busGrant = 1'b0;
        #1 chk("t2_buswait", busReqValid, 0);
        chk("t2_nodone_c6", done, 0);
        tick();
        tick();
        chk("t2_nodone_c8", done, 0);
        tick(); busDone = 1'b1;
        #1 chk("t2_nodone_c9", done, 0);
        tick(); busDone = 1'b0;
        #1 chk("t2_done", done, 1);
        chk("t2_lruway", lruWay, 2);
        tick();
        chk("t2_misscnt", missCount, 1);
        chk("t2_writecnt", writeCount, 1);
        chk("t2_hitcnt", hitCount, 1);

        // L1 DW hit on Shared line: invalidate on bus, grant in the first request cycle
        l1Valid = 1'b1; l1Op = L1_DW; l1Addr = 32'h0000_3000;
        lookupHit = 1'b1; lookupWay = 3'd3; lookupMesi = MESI_S;
        #1 chk("t3_ready", l1Ready, 1);
        tick(); l1Valid = 1'b0;
        tick();
        tick(); busGrant = 1'b1;
        #1 chk("t3_busreq", busReqValid, 1);
        chk("t3_busop", busReqOp, BUS_I);
        tick(); busGrant = 1'b0; busDone = 1'b1;
        #1 chk("t3_buswait", busReqValid, 0);
        tick(); busDone = 1'b0;
        #1 chk("t3_done", done, 1);
        chk("t3_lruway", lruWay, 3);
        tick();
        chk("t3_hitcnt", hitCount, 2);
        chk("t3_writecnt", writeCount, 2);

        // Snoops: R hit in M, then R hit in E
        snoop(BUS_R, MESI_M, 1'b1);
        snoop(BUS_R, MESI_E, 1'b0);
        chk("snp_nocount", hitCount, 2);

        // Both requesters held high: S,S,S,L,S,S,S,L
        l1Valid = 1'b1; l1Op = L1_DR; l1Addr = 32'h0000_5540;
        snoopValid = 1'b1; snoopOp = BUS_R; snoopAddr = 32'h0000_6600;
        lookupHit = 1'b1; lookupWay = 3'd1; lookupMesi = MESI_E;
        #1;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!(l1Ready || snoopReady) && n < 8) begin
                tick();
                n++;
            end
            chk("arb_grant_seen", n < 8, 1);
            chk("arb_l1_winner", l1Ready, (i % 4) == 3);
            chk("arb_snp_winner", snoopReady, (i % 4) != 3);
            tick();
        end
        l1Valid = 1'b0; snoopValid = 1'b0;
        tick();
        tick();
        chk("arb_last_done", done, 1);
        tick();
        chk("arb_hitcnt", hitCount, 4);
        chk("arb_readcnt", readCount, 3);

        // Saturation at all-ones (7 with 3-bit counters); reserved op 3 counts as a read
        l1_hit(L1_IR, 32'h0000_7000, 3'd4);
        l1_hit(L1_DR, 32'h0000_7040, 3'd0);
        chk("sat_hit6", hitCount, 6);
        l1_hit(L1_DR, 32'h0000_7080, 3'd7);
        chk("sat_hit7", hitCount, 7);
        l1_hit(2'd3, 32'h0000_70c0, 3'd7);
        chk("sat_hit_stuck", hitCount, 7);
        chk("sat_read", readCount, 7);
        chk("sat_miss", missCount, 1);
        chk("sat_write", writeCount, 2);

        // Reset asserted while in BUS_WAIT
        l1Valid = 1'b1; l1Op = L1_DR; l1Addr = 32'h0000_8000;
        lookupHit = 1'b0; lookupWay = 3'd4; lookupMesi = MESI_I;
        #1 chk("rst_t_ready", l1Ready, 1);
        tick(); l1Valid = 1'b0;
        tick();
        tick(); busGrant = 1'b1;
        #1 chk("rst_t_busop", busReqOp, BUS_R);
        tick(); busGrant = 1'b0;
        #1 chk("rst_t_wait", busReqValid, 0);
        rst_n = 1'b0;
        #1;
        chk("rstw_hitcnt", hitCount, 0);
        chk("rstw_readcnt", readCount, 0);
        chk("rstw_misscnt", missCount, 0);
        chk("rstw_addr", lookupAddr, 0);
        chk("rstw_lruway", lruWay, 0);
        chk("rstw_done", done, 0);
        tick();
        rst_n = 1'b1;
        #1 chk("rstw_idle_noready", l1Ready, 0);
        tick();
        chk("rstw_idle_nobus", busReqValid, 0);
        l1_hit(L1_DR, 32'h0000_9000, 3'd1);
        chk("post_rst_hitcnt", hitCount, 1);
        chk("post_rst_misscnt", missCount, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
